// File: rtl/alu_pkg.sv
// Shared ALU issue-stage definitions: ALU op encodings, ALUOp classes,
// funct/opcode constants, stage control record and the ALU control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_NOP = 4'd15;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;

    typedef struct packed {
        logic [3:0] op;
        logic       illegal;
    } alu_dec_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic       illegal;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ctrl_t;

    function automatic alu_dec_t alu_decode(input logic [1:0] alu_op,
                                            input logic [5:0] funct,
                                            input logic [5:0] opcode);
        alu_dec_t dec;
        dec.op      = ALU_NOP;
        dec.illegal = 1'b1;
        case (alu_op)
            ALUOP_ADD: begin dec.op = ALU_ADD; dec.illegal = 1'b0; end
            ALUOP_SUB: begin dec.op = ALU_SUB; dec.illegal = 1'b0; end
            ALUOP_RTYPE: begin
                dec.illegal = 1'b0;
                case (funct)
                    FN_ADD, FN_ADDU: dec.op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.op = ALU_SUB;
                    FN_AND:          dec.op = ALU_AND;
                    FN_OR:           dec.op = ALU_OR;
                    FN_NOR:          dec.op = ALU_NOR;
                    FN_SLT, FN_SLTU: dec.op = ALU_SLT;
                    default: begin dec.op = ALU_NOP; dec.illegal = 1'b1; end
                endcase
            end
            ALUOP_ITYPE: begin
                dec.illegal = 1'b0;
                case (opcode)
                    OPC_ADDI, OPC_ADDIU: dec.op = ALU_ADD;
                    OPC_ANDI:            dec.op = ALU_AND;
                    OPC_ORI:             dec.op = ALU_OR;
                    OPC_SLTI:            dec.op = ALU_SLT;
                    default: begin dec.op = ALU_NOP; dec.illegal = 1'b1; end
                endcase
            end
            default: begin dec.op = ALU_NOP; dec.illegal = 1'b1; end
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// One operand's forwarding select: EX/MEM beats MEM/WB, register $0 is never
// forwarded, otherwise the registered register-file value passes through.
module alu_fwd_mux #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       reg_i,
    input  logic [WIDTH-1:0] reg_data_i,
    input  logic             exm_reg_write_i,
    input  logic [4:0]       exm_rd_i,
    input  logic [WIDTH-1:0] exm_result_i,
    input  logic             mwb_reg_write_i,
    input  logic [4:0]       mwb_rd_i,
    input  logic [WIDTH-1:0] mwb_result_i,
    output logic [WIDTH-1:0] data_o
);

    // priority forward select
    always_comb begin
        data_o = reg_data_i;
        if (exm_reg_write_i && (exm_rd_i == reg_i) && (reg_i != 5'd0)) begin
            data_o = exm_result_i;
        end else if (mwb_reg_write_i && (mwb_rd_i == reg_i) && (reg_i != 5'd0)) begin
            data_o = mwb_result_i;
        end else begin
            data_o = reg_data_i;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register stage: decodes ALU control, forms the immediate, and presents
// forwarded operands to the ALU with bubble/freeze/kill handling.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_alu_op,
    input  logic [5:0]       id_funct,
    input  logic [5:0]       id_opcode,
    input  logic [15:0]      id_imm16,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic             stall,
    input  logic             hold,
    input  logic             flush,
    input  logic             exm_reg_write,
    input  logic [4:0]       exm_rd,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             mwb_reg_write,
    input  logic [4:0]       mwb_rd,
    input  logic [WIDTH-1:0] mwb_result,
    output logic             ex_valid,
    output logic [OPW-1:0]   ex_alu_op,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [4:0]       ex_dest,
    output logic             ex_reg_write,
    output logic             ex_illegal
);

    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rs_data_q, rs_data_d;
    logic [WIDTH-1:0] rt_data_q, rt_data_d;
    logic [WIDTH-1:0] imm_q, imm_d;

    alu_dec_t         dec_s;
    logic [WIDTH-1:0] imm_ext_s;
    logic [WIDTH-1:0] fwd_rs_s, fwd_rt_s;

    assign dec_s     = alu_decode(id_alu_op, id_funct, id_opcode);
    // andi/ori take a logical immediate; everything else is arithmetic
    assign imm_ext_s = ((id_opcode == OPC_ANDI) || (id_opcode == OPC_ORI))
                     ? {{(WIDTH-16){1'b0}}, id_imm16}
                     : {{(WIDTH-16){id_imm16[15]}}, id_imm16};

    alu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs (
        .reg_i           (ctrl_q.rs),
        .reg_data_i      (rs_data_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .data_o          (fwd_rs_s)
    );

    alu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rt (
        .reg_i           (ctrl_q.rt),
        .reg_data_i      (rt_data_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .data_o          (fwd_rt_s)
    );

    // next-state select: flush > hold > stall > load
    always_comb begin
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (flush || (stall && !hold)) begin
            ctrl_d    = '0;
            rs_data_d = {WIDTH{1'b0}};
            rt_data_d = {WIDTH{1'b0}};
            imm_d     = {WIDTH{1'b0}};
        end else if (hold) begin
            // refresh data so a producer retiring during the freeze is kept
            rs_data_d = fwd_rs_s;
            rt_data_d = fwd_rt_s;
        end else begin
            ctrl_d.valid     = id_valid;
            ctrl_d.op        = dec_s.op;
            ctrl_d.illegal   = dec_s.illegal;
            ctrl_d.alu_src   = id_alu_src;
            ctrl_d.reg_dst   = id_reg_dst;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.rs        = id_rs;
            ctrl_d.rt        = id_rt;
            ctrl_d.rd        = id_rd;
            rs_data_d        = id_rs_data;
            rt_data_d        = id_rt_data;
            imm_d            = imm_ext_s;
        end
    end

    // ID/EX boundary register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            rs_data_q <= {WIDTH{1'b0}};
            rt_data_q <= {WIDTH{1'b0}};
            imm_q     <= {WIDTH{1'b0}};
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_alu_op     = OPW'(ctrl_q.op);
    assign ex_a          = fwd_rs_s;
    assign ex_store_data = fwd_rt_s;
    assign ex_b          = ctrl_q.alu_src ? imm_q : fwd_rt_s;
    assign ex_dest       = ctrl_q.reg_dst ? ctrl_q.rd : ctrl_q.rt;
    assign ex_reg_write  = ctrl_q.reg_write & ctrl_q.valid & ~ctrl_q.illegal;
    assign ex_illegal    = ctrl_q.illegal & ctrl_q.valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural stage model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_alu_src, id_reg_dst, id_reg_write;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct, id_opcode;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic        stall, hold, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid, ex_reg_write, ex_illegal;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_dest;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference tables: legal funct / opcode -> ALU op code
    int fn_tab[int];
    int op_tab[int];

    // Model of what the stage currently holds
    logic        m_valid, m_ill, m_src, m_dst, m_rw;
    logic [3:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;

    alu_issue_stage #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_opcode(id_opcode), .id_imm16(id_imm16), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .stall(stall), .hold(hold), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
        if (r != 5'd0 && exm_reg_write && exm_rd == r) return exm_result;
        if (r != 5'd0 && mwb_reg_write && mwb_rd == r) return mwb_result;
        return d;
    endfunction

    // returns {illegal, op}
    function automatic logic [4:0] mdec();
        int code;
        code = -1;
        case (id_alu_op)
            2'd0: code = 2;
            2'd1: code = 6;
            2'd2: if (fn_tab.exists(int'(id_funct))) code = fn_tab[int'(id_funct)];
            default: if (op_tab.exists(int'(id_opcode))) code = op_tab[int'(id_opcode)];
        endcase
        if (code < 0) return {1'b1, 4'd15};
        return {1'b0, 4'(code)};
    endfunction

    always @(posedge clk) begin
        if (!rst_n || flush || (stall && !hold)) begin
            m_valid <= 1'b0; m_ill <= 1'b0; m_src <= 1'b0; m_dst <= 1'b0; m_rw <= 1'b0;
            m_op <= 4'd0; m_rs <= 5'd0; m_rt <= 5'd0; m_rd <= 5'd0;
            m_rsd <= 32'd0; m_rtd <= 32'd0; m_imm <= 32'd0;
        end else if (hold) begin
            m_rsd <= mfwd(m_rs, m_rsd);
            m_rtd <= mfwd(m_rt, m_rtd);
        end else begin
            m_valid <= id_valid; m_src <= id_alu_src; m_dst <= id_reg_dst; m_rw <= id_reg_write;
            {m_ill, m_op} <= mdec();
            m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd;
            m_rsd <= id_rs_data; m_rtd <= id_rt_data;
            m_imm <= (id_opcode == 6'h0C || id_opcode == 6'h0D) ? {16'h0000, id_imm16}
                                                               : {{16{id_imm16[15]}}, id_imm16};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",     32'(ex_valid),      32'(m_valid));
            chk("alu_op",    32'(ex_alu_op),     32'(m_op));
            chk("a",         ex_a,               mfwd(m_rs, m_rsd));
            chk("store",     ex_store_data,      mfwd(m_rt, m_rtd));
            chk("b",         ex_b,               m_src ? m_imm : mfwd(m_rt, m_rtd));
            chk("dest",      32'(ex_dest),       32'(m_dst ? m_rd : m_rt));
            chk("reg_write", 32'(ex_reg_write),  32'(m_rw && m_valid && !m_ill));
            chk("illegal",   32'(ex_illegal),    32'(m_ill && m_valid));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_alu_op = 2'd0; id_funct = 6'd0; id_opcode = 6'd0;
        id_imm16 = 16'd0; id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_rs_data = 32'd0; id_rt_data = 32'd0;
        stall = 1'b0; hold = 1'b0; flush = 1'b0;
        exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
        mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_result = 32'd0;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        id_valid = 1'b1; id_alu_op = 2'b10; id_funct = fn; id_alu_src = 1'b0;
        id_reg_dst = 1'b1; id_reg_write = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b;
    endtask

    task automatic itype(input logic [5:0] opc, input logic [15:0] imm);
        id_valid = 1'b1; id_alu_op = 2'b11; id_opcode = opc; id_imm16 = imm;
        id_alu_src = 1'b1; id_reg_dst = 1'b0; id_reg_write = 1'b1;
        id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'd9;
    endtask

    initial begin
        logic [5:0] legal_fn [9];
        logic [5:0] legal_opc [5];
        legal_fn  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};
        legal_opc = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};
        fn_tab[32'h20] = 2; fn_tab[32'h21] = 2; fn_tab[32'h22] = 6; fn_tab[32'h23] = 6;
        fn_tab[32'h24] = 0; fn_tab[32'h25] = 1; fn_tab[32'h27] = 12;
        fn_tab[32'h2A] = 7; fn_tab[32'h2B] = 7;
        op_tab[32'h08] = 2; op_tab[32'h09] = 2; op_tab[32'h0C] = 0;
        op_tab[32'h0D] = 1; op_tab[32'h0A] = 7;

        idle();
        rst_n = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_op",    32'(ex_alu_op), 32'd0);
        chk("rst_a",     ex_a, 32'd0);
        chk("rst_dest",  32'(ex_dest), 32'd0);
        rst_n = 1'b1;

        rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        step();
        chk("radd_op", 32'(ex_alu_op), 32'd2);
        chk("radd_a",  ex_a, 32'd5);
        chk("radd_b",  ex_b, 32'd7);
        chk("radd_dest", 32'(ex_dest), 32'd3);
        chk("radd_rw", 32'(ex_reg_write), 32'd1);

        itype(6'h0C, 16'hFFFF); step();
        chk("andi_b", ex_b, 32'h0000FFFF); chk("andi_op", 32'(ex_alu_op), 32'd0);
        itype(6'h0D, 16'h8000); step();
        chk("ori_b", ex_b, 32'h00008000);  chk("ori_op", 32'(ex_alu_op), 32'd1);
        itype(6'h08, 16'hFFFF); step();
        chk("addi_b", ex_b, 32'hFFFFFFFF); chk("addi_op", 32'(ex_alu_op), 32'd2);

        idle();
        id_valid = 1'b1; id_rs = 5'd4; id_rs_data = 32'd1;
        exm_reg_write = 1'b1; exm_rd = 5'd4; exm_result = 32'hAA;
        mwb_reg_write = 1'b1; mwb_rd = 5'd4; mwb_result = 32'hBB;
        step();
        chk("fwd_exm", ex_a, 32'hAA);
        exm_reg_write = 1'b0; #1;
        chk("fwd_mwb", ex_a, 32'hBB);
        id_rs = 5'd0; id_rs_data = 32'd0; exm_reg_write = 1'b1; exm_rd = 5'd0;
        mwb_rd = 5'd0;
        step();
        chk("fwd_r0", ex_a, 32'd0);

        idle();
        rtype(6'h20, 5'd1, 5'd5, 5'd6, 32'd3, 32'd1);
        step();
        hold = 1'b1; mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'h55;
        id_rd = 5'd9; id_funct = 6'h22;
        step();
        mwb_reg_write = 1'b0; #1;
        chk("hold_b", ex_b, 32'h55);
        chk("hold_dest", 32'(ex_dest), 32'd6);
        chk("hold_op", 32'(ex_alu_op), 32'd2);
        step();
        chk("hold_b2", ex_b, 32'h55);
        hold = 1'b0;

        rtype(6'h25, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2);
        step();
        stall = 1'b1; step();
        chk("stall_valid", 32'(ex_valid), 32'd0);
        chk("stall_rw", 32'(ex_reg_write), 32'd0);
        stall = 1'b0; step();
        stall = 1'b1; hold = 1'b1; id_rd = 5'd8; step();
        chk("sh_valid", 32'(ex_valid), 32'd1);
        chk("sh_dest", 32'(ex_dest), 32'd7);
        stall = 1'b0; flush = 1'b1; step();
        chk("fh_valid", 32'(ex_valid), 32'd0);
        flush = 1'b0; hold = 1'b0;

        rtype(6'h3F, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
        step();
        chk("ill_op", 32'(ex_alu_op), 32'd15);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_rw", 32'(ex_reg_write), 32'd0);

        rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'h123, 32'h456);
        step();
        rst_n = 1'b0; step();
        chk("mrst_valid", 32'(ex_valid), 32'd0);
        chk("mrst_a", ex_a, 32'd0);
        chk("mrst_b", ex_b, 32'd0);
        chk("mrst_dest", 32'(ex_dest), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            hold          = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 7) == 0);
            id_valid      = ($urandom_range(0, 7) != 0);
            id_alu_op     = 2'($urandom_range(0, 3));
            id_funct      = $urandom_range(0, 3) != 0 ? legal_fn[$urandom_range(0, 8)] : 6'($urandom);
            id_opcode     = $urandom_range(0, 3) != 0 ? legal_opc[$urandom_range(0, 4)] : 6'($urandom);
            id_imm16      = 16'($urandom);
            id_alu_src    = 1'($urandom);
            id_reg_dst    = 1'($urandom);
            id_reg_write  = 1'($urandom);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_rd         = 5'($urandom_range(0, 3));
            id_rs_data    = $urandom;
            id_rt_data    = $urandom;
            exm_reg_write = 1'($urandom);
            exm_rd        = 5'($urandom_range(0, 3));
            exm_result    = $urandom;
            mwb_reg_write = 1'($urandom);
            mwb_rd        = 5'($urandom_range(0, 3));
            mwb_result    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that produces the 4-bit ALU opcode and both ALU operands for the MIPS datapath ALU.
- Decodes ALUOp, funct and opcode into the ALU op encoding and forms immediates.
- Registers everything on the ID/EX boundary and applies EX/MEM and MEM/WB forwarding on the operands it presents to the ALU.
- Handles bubble (stall), freeze (hold) and kill (flush) controls.

Parameters:
- WIDTH, 32, datapath/operand width
- OPW, 4, ALU opcode width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 I-type (use opcode)
- id_funct  in  6  instruction[5:0]
- id_opcode  in  6  instruction[31:26]
- id_imm16  in  16  instruction[15:0]
- id_alu_src  in  1  1: operand b is immediate
- id_reg_dst  in  1  1: dest = rd, 0: dest = rt
- id_reg_write  in  1  instruction writes the register file
- id_rs, id_rt, id_rd  in  5 each  register numbers
- id_rs_data, id_rt_data  in  WIDTH each  register-file read data
- stall  in  1  load-use bubble request
- hold  in  1  downstream busy, freeze stage
- flush  in  1  kill instruction in stage
- exm_reg_write, exm_rd, exm_result  in  1/5/WIDTH  EX/MEM producer
- mwb_reg_write, mwb_rd, mwb_result  in  1/5/WIDTH  MEM/WB producer
- ex_valid  out  1  stage holds a live instruction
- ex_alu_op  out  OPW  to ALU op
- ex_a, ex_b  out  WIDTH  to ALU a/b
- ex_store_data  out  WIDTH  forwarded rt value (for sw)
- ex_dest  out  5  destination register
- ex_reg_write  out  1  qualified write enable
- ex_illegal  out  1  unsupported encoding in stage

Behaviour:
- Reset (rst_n=0 at edge): all registered fields are 0.
  - Outputs: ex_valid=0, ex_alu_op=0, ex_dest=0, ex_reg_write=0, ex_illegal=0.
  - ex_a, ex_b and ex_store_data are 0, provided no forwarding match.
  - Reset overrides every other control.
- Per-edge priority is reset > flush > hold > stall > load.
  - flush: load a bubble (valid=0, reg_write=0, illegal=0, op=0); data fields don't-care, driven 0.
  - hold: all control fields are kept. The registered rs/rt data fields are overwritten with the current forwarded values, so a producer that retires during the freeze is not lost.
  - stall: load a bubble, as for flush.
  - else: capture all id_* fields. Valid = id_valid.
- Latency: 1 cycle from ID inputs to ex_alu_op and ex_dest. Forwarding is combinational from the registered values in the same cycle.
- Decode, ALU encoding:
  - ALUOp 00 -> 2 (add); 01 -> 6 (sub).
  - ALUOp 10, funct: 0x20/0x21 -> 2; 0x22/0x23 -> 6; 0x24 -> 0; 0x25 -> 1; 0x27 -> 12; 0x2A/0x2B -> 7.
  - ALUOp 11, opcode: 0x08/0x09 -> 2; 0x0C -> 0; 0x0D -> 1; 0x0A -> 7.
  - Any other encoding: op=15 (ALU returns 0), illegal=1.
- Immediate: opcode 0x0C/0x0D zero-extends imm16; all other opcodes sign-extend.
- Forwarding, each of rs and rt:
  - If exm_reg_write and exm_rd==reg and reg!=0: use exm_result.
  - Else if mwb_reg_write and mwb_rd==reg and reg!=0: use mwb_result.
  - Else use the registered data.
  - EX/MEM always beats MEM/WB. $0 is never forwarded.
- Operands:
  - ex_a = forwarded rs.
  - ex_store_data = forwarded rt.
  - ex_b = alu_src ? extended immediate : forwarded rt.
- Destination and write enable:
  - ex_dest = reg_dst ? rd : rt.
  - ex_reg_write = reg_write & valid & ~illegal.
  - ex_illegal = illegal & valid.
- Simultaneous stall+hold: hold wins; the bubble is not inserted until hold drops. Upstream holds ID meanwhile.
- Flush during hold: the instruction is killed on that edge.

Decomposition:
- Package alu_pkg:
  - ALU op constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_NOP=15.
  - ALUOp class constants.
  - funct and opcode constants.
- Sub-module alu_fwd_mux: one operand's 3-way priority forward select including the $0 guard. Instantiated twice (rs, rt).
- Decode is a combinational function in the package.

Test Plan:
- R-type add: id_alu_op=10, funct=0x20, rs_data=5, rt_data=7, reg_dst=1, rd=3 -> next cycle ex_alu_op=2, ex_a=5, ex_b=7, ex_dest=3, ex_reg_write=1.
- andi with imm16=0xFFFF and ori with imm16=0x8000 -> ex_b=0x0000FFFF, op=0 and ex_b=0x00008000, op=1. addi with imm16=0xFFFF -> ex_b=0xFFFFFFFF, op=2.
- Forwarding, rs=4, regfile data=1:
  - exm_rd=4 result=0xAA and mwb_rd=4 result=0xBB, both write -> ex_a=0xAA.
  - Drop exm_reg_write -> ex_a=0xBB.
  - rs=0 with exm_rd=0 -> ex_a=0.
- Hold while mwb_rd matches rt (result=0x55), then the producer retires with no matches and hold released -> ex_b stays 0x55 throughout, control fields unchanged.
- stall -> next cycle ex_valid=0, ex_reg_write=0. stall+hold together -> stage unchanged. flush+hold -> ex_valid=0.
- funct=0x3F R-type -> ex_alu_op=15, ex_illegal=1, ex_reg_write=0. Assert rst_n=0 mid-stream -> all outputs 0 at the next edge.
